ign_output_router: RTL
======================

# ign_output_router

Parametrised ignition output stage that sits between the per-cylinder ignition drivers and the coil pins. It generalises the fixed four-channel, distributor-or-individual output mux to N_CH channels with three routing modes. It adds per-output hardware protection: a max-dwell cutoff with a sticky fault flag, and a minimum off-time lockout. Routing mode changes are deferred until every channel is idle, so a dwell in progress is never split across modes.

## Interface

Parameters:
- N_CH, default 4: number of ignition channels; must be even, range 2..8.
- CNT_W, default 16: width of the dwell/off-time counters and limit inputs.

Ports:
- clk  in  1  system EFI clock; one clock only.
- reset_n  in  1  asynchronous, active-low reset.
- synced  in  1  synchronizer lock; low forces every output off.
- mode_req  in  2  requested routing: 0 individual, 1 wasted spark, 2 distributor, 3 all off.
- ch_en  in  N_CH  per-channel enable mask.
- drv_in  in  N_CH  raw coil requests from the ign_driver instances; bit k belongs to cylinder k.
- max_dwell  in  CNT_W  maximum on-time in clk cycles; 0 disables the cutoff.
- min_off  in  CNT_W  minimum off-time in clk cycles.
- fault_clr  in  1  single-cycle pulse; clears all fault bits.
- ign_out  out  N_CH  registered coil drive outputs.
- mode_active  out  2  mode currently applied.
- fault  out  N_CH  sticky max-dwell cutoff flag, one bit per output.

## Operation

- Routing is combinational into src[N_CH-1:0], with H = N_CH/2:
  - Mode 0: src[k] = drv_in[k] & ch_en[k].
  - Mode 1: p = drv_in[k] | drv_in[k+H] for k < H; src[k] = p & ch_en[k]; src[k+H] = p & ch_en[k+H].
  - Mode 2: src[0] = |(drv_in & ch_en); src[k] = 0 for k ≥ 1.
  - Mode 3: src = 0.
- Mode commit: mode_active <= mode_req on any clock edge where one of these holds:
  - drv_in == 0 and every channel FSM is in IDLE, or
  - synced == 0.
  - Otherwise the request stays pending. The new mode applies to src from the next cycle.
- Per-output FSM, one per channel, with states IDLE, ON, CUT and OFF:
  - IDLE: if src, go to ON with on_cnt = 1.
  - ON: on_cnt increments by 1 and saturates at 2^CNT_W-1.
    - If src = 0, go to OFF with off_cnt = 1.
    - Else if max_dwell != 0 and on_cnt >= max_dwell, go to CUT and set fault[k].
  - CUT: output off. Wait for src = 0, then go to OFF with off_cnt = 1. This prevents re-firing from the same request.
  - OFF: off_cnt increments by 1 and saturates.
    - Once off_cnt >= min_off: if src, go to ON with on_cnt = 1; else go to IDLE.
- ign_out[k] is registered and equals (next state == ON).
- synced low: all FSMs go to IDLE on the next edge and ign_out goes to 0. CUT and OFF are abandoned and min_off is ignored. Fault bits are retained.
- fault_clr clears all fault bits. If a set and a clear land on the same edge, the set wins for that bit.
- Asynchronous reset values:
  - ign_out = 0, fault = 0, mode_active = 0.
  - All FSMs in IDLE; all counters 0.

## Timing

- Latency from drv_in rising to ign_out rising is 1 cycle, when the channel is in IDLE or its OFF time has expired.
- Latency from drv_in falling to ign_out falling is 1 cycle.
- Max-dwell cutoff: ign_out stays high for exactly max_dwell cycles, then falls.
- After any ign_out fall, ign_out stays low for at least max(min_off, 1) cycles. A request still held when OFF expires re-asserts ign_out on that edge.
- A mode change requested mid-dwell takes effect on the first edge where the idle condition holds. mode_active updates on that edge and routing uses it from the next cycle.
- synced falling to all outputs low: 1 cycle.
- Simultaneous src drop and max_dwell reached in ON: the drop wins. The FSM goes to OFF and fault is not set.

## Test plan

- Mode 0, N_CH=4, ch_en=4'b1111, max_dwell=0, min_off=0: a 100-cycle pulse on drv_in[2] -> ign_out[2] high for 100 cycles, delayed 1 cycle; other outputs 0.
- Mode 1, N_CH=4: pulse on drv_in[1] -> ign_out[1] and ign_out[3] high together; with ch_en[3]=0, only ign_out[1] goes high.
- Mode 2: staggered pulses on drv_in[0..3] -> all pulses appear on ign_out[0]; ign_out[3:1] stay 0; ch_en[2]=0 suppresses cylinder 2's pulse.
- max_dwell=50, drv_in[0] held 200 cycles -> ign_out[0] high exactly 50 cycles and fault[0]=1. Raising drv_in again is ignored until it drops; a fault_clr pulse then gives fault[0]=0.
- min_off=20: drv_in[0] drops for 5 cycles, then rises -> ign_out[0] stays low for 20 cycles, then re-asserts.
- With drv_in[0] high in mode 0, mode_req set to 2 -> mode_active stays 0 until drv_in[0] falls and all FSMs reach IDLE, then becomes 2. synced falling mid-dwell -> ign_out = 0 on the next cycle with fault unchanged. reset_n asserted asynchronously mid-dwell -> ign_out, fault and mode_active go to 0 immediately.

Source files
------------

// File: rtl/ign_output_router.sv
// Ignition output stage: routes per-cylinder coil requests to N_CH outputs in one of
// three modes, with per-output max-dwell cutoff (sticky fault) and minimum off-time.
module ign_output_router #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             synced,
    input  logic [1:0]       mode_req,
    input  logic [N_CH-1:0]  ch_en,
    input  logic [N_CH-1:0]  drv_in,
    input  logic [CNT_W-1:0] max_dwell,
    input  logic [CNT_W-1:0] min_off,
    input  logic             fault_clr,
    output logic [N_CH-1:0]  ign_out,
    output logic [1:0]       mode_active,
    output logic [N_CH-1:0]  fault
);

    localparam int unsigned H = N_CH / 2;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StOn, StCut, StOff} state_e;

    state_e           st_q      [N_CH];
    logic [CNT_W-1:0] on_cnt_q  [N_CH];
    logic [CNT_W-1:0] off_cnt_q [N_CH];
    logic [N_CH-1:0]  src;
    logic             all_idle;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    always_comb begin
        src = '0;
        case (mode_active)
            2'd0: src = drv_in & ch_en;
            2'd1: begin
                for (int unsigned k = 0; k < H; k++) begin
                    src[k]   = (drv_in[k] | drv_in[k+H]) & ch_en[k];
                    src[k+H] = (drv_in[k] | drv_in[k+H]) & ch_en[k+H];
                end
            end
            2'd2:    src[0] = |(drv_in & ch_en);
            default: src = '0;
        endcase
    end

    always_comb begin
        all_idle = 1'b1;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (st_q[k] != StIdle) all_idle = 1'b0;
        end
    end

    // Mode switches only between dwells so no pulse is split across two routings.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_active <= 2'd0;
        end else if (!synced || (drv_in == '0 && all_idle)) begin
            mode_active <= mode_req;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                st_q[k]      <= StIdle;
                on_cnt_q[k]  <= '0;
                off_cnt_q[k] <= '0;
            end
            ign_out <= '0;
            fault   <= '0;
        end else begin
            if (fault_clr) fault <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (!synced) begin
                    st_q[k]    <= StIdle;
                    ign_out[k] <= 1'b0;
                end else begin
                    unique case (st_q[k])
                        StIdle: begin
                            if (src[k]) begin
                                st_q[k]     <= StOn;
                                on_cnt_q[k] <= CntOne;
                                ign_out[k]  <= 1'b1;
                            end else begin
                                ign_out[k]  <= 1'b0;
                            end
                        end
                        StOn: begin
                            on_cnt_q[k] <= sat_inc(on_cnt_q[k]);
                            // A falling request takes priority over the dwell limit.
                            if (!src[k]) begin
                                st_q[k]      <= StOff;
                                off_cnt_q[k] <= CntOne;
                                ign_out[k]   <= 1'b0;
                            end else if (max_dwell != '0 && on_cnt_q[k] >= max_dwell) begin
                                st_q[k]    <= StCut;
                                fault[k]   <= 1'b1;
                                ign_out[k] <= 1'b0;
                            end else begin
                                ign_out[k] <= 1'b1;
                            end
                        end
                        StCut: begin
                            ign_out[k] <= 1'b0;
                            if (!src[k]) begin
                                st_q[k]      <= StOff;
                                off_cnt_q[k] <= CntOne;
                            end
                        end
                        StOff: begin
                            off_cnt_q[k] <= sat_inc(off_cnt_q[k]);
                            if (off_cnt_q[k] >= min_off && src[k]) begin
                                st_q[k]     <= StOn;
                                on_cnt_q[k] <= CntOne;
                                ign_out[k]  <= 1'b1;
                            end else if (off_cnt_q[k] >= min_off) begin
                                st_q[k]    <= StIdle;
                                ign_out[k] <= 1'b0;
                            end else begin
                                ign_out[k] <= 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule
